// File: rtl/rstmgr_pkg.sv
// Shared types and index helpers for the reset sequencer.
package rstmgr_pkg;

  // Sequencer states: stretch the merged reset, release domains in order, idle.
  typedef enum logic [1:0] {
    RstHold,
    RstRelease,
    RstRun
  } rst_state_e;

  // Cause register layout: source bits first, then software, then power-on.
  function automatic int cause_sw_idx(input int num_src);
    return num_src;
  endfunction

  function automatic int cause_por_idx(input int num_src);
    return num_src + 1;
  endfunction

  // Layout for the default three-source configuration.
  localparam int DefNumSrc   = 3;
  localparam int CauseSwIdx  = cause_sw_idx(DefNumSrc);
  localparam int CausePorIdx = cause_por_idx(DefNumSrc);

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Multi-flop synchroniser for one asynchronous reset request bit.
module rst_sync #(
  parameter int Stages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_reg;

  // Shift the request through the chain; cleared by the system reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[Stages-2:0], d_i};
    end
  end

  assign q_o = sync_reg[Stages-1];

endmodule

// File: rtl/rst_seq_mgr.sv
// Reset sequencer: merges reset requests, stretches the merged reset and
// releases the reset domains one after another with a fixed gap.
// Optional sticky cause register enabled by defining RSTMGR_CAUSE_EN.
module rst_seq_mgr
  import rstmgr_pkg::*;
#(
  parameter int NumSrc        = 3,
  parameter int NumDom        = 3,
  parameter int SyncStages    = 2,
  parameter int StretchCycles = 16,
  parameter int ReleaseGap    = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumSrc-1:0] src_rst_i,
  input  logic              sw_rst_req_i,
  input  logic              cause_clr_i,
  output logic [NumDom-1:0] dom_rst_no,
  output logic              rst_busy_o,
  output logic [NumSrc+1:0] cause_o
);

  localparam int CntW     = $clog2(max_int(StretchCycles, ReleaseGap)) + 1;
  localparam int IdxW     = max_int(1, $clog2(NumDom + 1));
  localparam int CauseSw  = cause_sw_idx(NumSrc);
  localparam int CausePor = cause_por_idx(NumSrc);

  logic [NumSrc-1:0] src_sync;
  logic              req;

  rst_state_e        state_reg;
  logic [CntW-1:0]   cnt_reg;
  logic [IdxW-1:0]   idx_reg;
  logic [NumDom-1:0] dom_rst_reg;
  logic              busy_reg;

  // One synchroniser per asynchronous request source.
  for (genvar gi = 0; gi < NumSrc; gi++) begin : g_sync
    rst_sync #(
      .Stages (SyncStages)
    ) u_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (src_rst_i[gi]),
      .q_o   (src_sync[gi])
    );
  end

  assign req = (|src_sync) | sw_rst_req_i;

  // Sequencer FSM; a request in any state beats a pending release.
  always_ff @(posedge clk_i) begin
    if (rst_i || req) begin
      state_reg   <= RstHold;
      cnt_reg     <= '0;
      idx_reg     <= '0;
      dom_rst_reg <= '0;
      busy_reg    <= 1'b1;
    end else begin
      case (state_reg)
        RstHold: begin
          if (cnt_reg == CntW'(StretchCycles - 1)) begin
            dom_rst_reg[0] <= 1'b1;
            cnt_reg        <= '0;
            idx_reg        <= IdxW'(1);
            if (NumDom == 1) begin
              state_reg <= RstRun;
              busy_reg  <= 1'b0;
            end else begin
              state_reg <= RstRelease;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RstRelease: begin
          if (cnt_reg == CntW'(ReleaseGap - 1)) begin
            for (int d = 0; d < NumDom; d++) begin
              if (idx_reg == IdxW'(d)) begin
                dom_rst_reg[d] <= 1'b1;
              end
            end
            idx_reg <= idx_reg + 1'b1;
            cnt_reg <= '0;
            if (idx_reg == IdxW'(NumDom - 1)) begin
              state_reg <= RstRun;
              busy_reg  <= 1'b0;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= RstRun;
        end
      endcase
    end
  end

  assign dom_rst_no = dom_rst_reg;
  assign rst_busy_o = busy_reg;

`ifdef RSTMGR_CAUSE_EN
  logic [NumSrc+1:0] cause_reg;
  logic [NumSrc+1:0] cause_set;

  // New causes observed this cycle; these win over a simultaneous clear.
  always_comb begin
    cause_set                 = '0;
    cause_set[NumSrc-1:0]     = src_sync;
    cause_set[CauseSw]        = sw_rst_req_i;
  end

  // Sticky cause bits; system reset leaves only the power-on bit set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cause_reg           <= '0;
      cause_reg[CausePor] <= 1'b1;
    end else begin
      cause_reg <= (cause_clr_i ? '0 : cause_reg) | cause_set;
    end
  end

  assign cause_o = cause_reg;
`else
  logic unused_cause_clr;
  assign unused_cause_clr = cause_clr_i;
  assign cause_o          = '0;
`endif

endmodule
